// File: rtl/lcd_chrono_writer_if.sv
// LCD pin bundle for an HD44780-compatible panel in 8-bit write-only mode.
//   rs : 0 = command, 1 = data
//   rw : read/write select (the writer always drives 0)
//   e  : enable strobe
//   db : 8-bit data bus
// master = the controller driving the pins, slave = the panel or an observer.
interface lcd_chrono_writer_if;
    logic       rs;
    logic       rw;
    logic       e;
    logic [7:0] db;

    modport master (output rs, output rw, output e, output db);
    modport slave  (input  rs, input  rw, input  e, input  db);
endinterface

// File: rtl/lcd_chrono_writer.sv
// Chronometer display writer: initialises an HD44780 LCD after reset, then on
// every refresh rising edge snapshots the counters and writes "MM:SS.CC" plus
// a lap marker to line 1.
//   clk_in, reset      : clock, synchronous active-high reset
//   refresh            : frame request, rising edge taken only while idle
//   minutes/seconds/hundredths/lap_flag : live counter values
//   lcd                : LCD pins (rs, rw, e, db), all registered
//   busy               : high during init and while a frame is being written
//   frame_done         : one-cycle pulse in the final cycle of a frame
module lcd_chrono_writer #(
    parameter int unsigned INIT_WAIT = 1000000,
    parameter int unsigned E_PULSE   = 25,
    parameter int unsigned CMD_WAIT  = 2500,
    parameter int unsigned CLR_WAIT  = 100000
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       refresh,
    input  logic [7:0]                 minutes,
    input  logic [7:0]                 seconds,
    input  logic [7:0]                 hundredths,
    input  logic                       lap_flag,
    lcd_chrono_writer_if.master        lcd,
    output logic                       busy,
    output logic                       frame_done
);

    // Last cycle index of a write slot: setup + strobe + post-strobe wait.
    localparam int unsigned SLOT_CMD_LAST = E_PULSE + CMD_WAIT;
    localparam int unsigned SLOT_CLR_LAST = E_PULSE + CLR_WAIT;
    localparam int unsigned SLOT_MAX      = (SLOT_CLR_LAST > SLOT_CMD_LAST) ? SLOT_CLR_LAST : SLOT_CMD_LAST;
    localparam int unsigned CNT_MAX       = (INIT_WAIT > SLOT_MAX) ? INIT_WAIT : SLOT_MAX;
    localparam int unsigned CNT_W         = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W         = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, FRAME} state_t;

    state_t           state_q, state_n;
    cnt_t             cnt_q, cnt_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             rs_q, rs_n;
    logic [7:0]       db_q, db_n;
    logic             e_q, e_n;
    logic             busy_n;
    logic             done_n;
    logic [7:0]       snap_min_q, snap_min_n;
    logic [7:0]       snap_sec_q, snap_sec_n;
    logic [7:0]       snap_hun_q, snap_hun_n;
    logic             snap_lap_q, snap_lap_n;
    logic             refresh_prev;
    logic             refresh_rise_c;
    cnt_t             slot_last_c;

    // Init command table: function set 8-bit/2-line, display on, entry mode, clear.
    function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h38;
            4'd1:    b = 8'h0C;
            4'd2:    b = 8'h06;
            default: b = 8'h01;
        endcase
        return b;
    endfunction

    // Values above 99 are shown as 99; the raw snapshot is left untouched.
    function automatic logic [7:0] clamp99(input logic [7:0] v);
        return (v > 8'd99) ? 8'd99 : v;
    endfunction

    function automatic logic [7:0] tens_char(input logic [7:0] v);
        return 8'h30 + (clamp99(v) / 8'd10);
    endfunction

    function automatic logic [7:0] units_char(input logic [7:0] v);
        return 8'h30 + (clamp99(v) % 8'd10);
    endfunction

    // Frame byte for slot i: cursor command, then "MM:SS.CC" and lap marker.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i,
                                              input logic [7:0] mv,
                                              input logic [7:0] sv,
                                              input logic [7:0] hv,
                                              input logic       lv);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h80;
            4'd1:    b = tens_char(mv);
            4'd2:    b = units_char(mv);
            4'd3:    b = 8'h3A;
            4'd4:    b = tens_char(sv);
            4'd5:    b = units_char(sv);
            4'd6:    b = 8'h2E;
            4'd7:    b = tens_char(hv);
            4'd8:    b = units_char(hv);
            default: b = lv ? 8'h4C : 8'h20;
        endcase
        return b;
    endfunction

    assign refresh_rise_c = refresh & ~refresh_prev;

    // The clear command needs the long post-strobe wait.
    assign slot_last_c = (!rs_q && (db_q == 8'h01)) ? cnt_t'(SLOT_CLR_LAST) : cnt_t'(SLOT_CMD_LAST);

    // State register; the refresh history is tracked even through reset.
    always_ff @(posedge clk_in) begin
        refresh_prev <= refresh;
        if (reset) begin
            state_q    <= PWR_WAIT;
            cnt_q      <= '0;
            idx_q      <= '0;
            rs_q       <= 1'b0;
            db_q       <= 8'h00;
            e_q        <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            snap_min_q <= 8'h00;
            snap_sec_q <= 8'h00;
            snap_hun_q <= 8'h00;
            snap_lap_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            idx_q      <= idx_n;
            rs_q       <= rs_n;
            db_q       <= db_n;
            e_q        <= e_n;
            busy       <= busy_n;
            frame_done <= done_n;
            snap_min_q <= snap_min_n;
            snap_sec_q <= snap_sec_n;
            snap_hun_q <= snap_hun_n;
            snap_lap_q <= snap_lap_n;
        end
    end

    // Next-state and next-output logic; pin values are registered from here.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        idx_n      = idx_q;
        rs_n       = rs_q;
        db_n       = db_q;
        e_n        = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
        snap_min_n = snap_min_q;
        snap_sec_n = snap_sec_q;
        snap_hun_n = snap_hun_q;
        snap_lap_n = snap_lap_q;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == cnt_t'(INIT_WAIT - 1)) begin
                    state_n = INIT;
                    cnt_n   = '0;
                    idx_n   = '0;
                    rs_n    = 1'b0;
                    db_n    = init_cmd(4'd0);
                end else begin
                    cnt_n = cnt_q + cnt_t'(1);
                end
            end

            INIT, FRAME: begin
                if (cnt_q == slot_last_c) begin
                    cnt_n = '0;
                    if ((state_q == INIT && idx_q == 4'd3) || (state_q == FRAME && idx_q == 4'd9)) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        idx_n = IDX_W'(idx_q + 4'd1);
                        if (state_q == INIT) begin
                            rs_n = 1'b0;
                            db_n = init_cmd(IDX_W'(idx_q + 4'd1));
                        end else begin
                            rs_n = 1'b1;
                            db_n = frame_byte(IDX_W'(idx_q + 4'd1), snap_min_q, snap_sec_q,
                                              snap_hun_q, snap_lap_q);
                        end
                    end
                end else begin
                    cnt_n  = cnt_q + cnt_t'(1);
                    // Strobe occupies slot cycles 1..E_PULSE.
                    e_n    = (cnt_q < cnt_t'(E_PULSE));
                    done_n = (state_q == FRAME) && (idx_q == 4'd9) &&
                             ((cnt_q + cnt_t'(1)) == slot_last_c);
                end
            end

            IDLE: begin
                if (refresh_rise_c) begin
                    snap_min_n = minutes;
                    snap_sec_n = seconds;
                    snap_hun_n = hundredths;
                    snap_lap_n = lap_flag;
                    busy_n     = 1'b1;
                    state_n    = FRAME;
                    cnt_n      = '0;
                    idx_n      = '0;
                    rs_n       = 1'b0;
                    db_n       = 8'h80;
                end
            end

            default: state_n = PWR_WAIT;
        endcase
    end

    assign lcd.rs = rs_q;
    assign lcd.rw = 1'b0;
    assign lcd.e  = e_q;
    assign lcd.db = db_q;

endmodule

// File: tb/tb_lcd_chrono_writer.sv
// Bench for lcd_chrono_writer: a cycle-expanded reference (list of writes ->
// per-cycle expected pins) checked every cycle, plus literal byte lists,
// busy lengths and frame counts.
module tb_lcd_chrono_writer;

    localparam int unsigned INIT_WAIT = 20;
    localparam int unsigned E_PULSE   = 2;
    localparam int unsigned CMD_WAIT  = 3;
    localparam int unsigned CLR_WAIT  = 10;
    localparam int          MAXW      = 500;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       refresh = 1'b0;
    logic [7:0] minutes = 8'd0;
    logic [7:0] seconds = 8'd0;
    logic [7:0] hundredths = 8'd0;
    logic       lap_flag = 1'b0;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    lcd_chrono_writer_if lcd ();

    lcd_chrono_writer #(
        .INIT_WAIT (INIT_WAIT),
        .E_PULSE   (E_PULSE),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .refresh    (refresh),
        .minutes    (minutes),
        .seconds    (seconds),
        .hundredths (hundredths),
        .lap_flag   (lap_flag),
        .lcd        (lcd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference: expected pins per cycle ----------------
    typedef struct packed {
        logic       idle;
        logic       rs;
        logic [7:0] db;
        logic       e;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic model_valid = 1'b0;
    logic m_prev = 1'b0;

    task automatic push_write(input logic rs, input logic [7:0] db, input logic last);
        int w;
        w = (!rs && db == 8'h01) ? CLR_WAIT : CMD_WAIT;
        q.push_back('{1'b0, rs, db, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < E_PULSE; i++) q.push_back('{1'b0, rs, db, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < w; i++) q.push_back('{1'b0, rs, db, 1'b0, 1'b1, last && (i == w - 1)});
    endtask

    task automatic push_init();
        for (int i = 0; i < INIT_WAIT; i++) q.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        push_write(1'b0, 8'h38, 1'b0);
        push_write(1'b0, 8'h0C, 1'b0);
        push_write(1'b0, 8'h06, 1'b0);
        push_write(1'b0, 8'h01, 1'b0);
    endtask

    task automatic push_frame(input int m, input int s, input int h, input logic l);
        int mm, ss, hh;
        mm = (m > 99) ? 99 : m;
        ss = (s > 99) ? 99 : s;
        hh = (h > 99) ? 99 : h;
        push_write(1'b0, 8'h80, 1'b0);
        push_write(1'b1, 8'(48 + mm / 10), 1'b0);
        push_write(1'b1, 8'(48 + mm % 10), 1'b0);
        push_write(1'b1, 8'h3A, 1'b0);
        push_write(1'b1, 8'(48 + ss / 10), 1'b0);
        push_write(1'b1, 8'(48 + ss % 10), 1'b0);
        push_write(1'b1, 8'h2E, 1'b0);
        push_write(1'b1, 8'(48 + hh / 10), 1'b0);
        push_write(1'b1, 8'(48 + hh % 10), 1'b0);
        push_write(1'b1, l ? 8'h4C : 8'h20, 1'b1);
    endtask

    // Advance the reference on each active edge using the inputs seen there.
    always @(posedge clk_in) begin
        logic rise;
        rise = refresh && !m_prev;
        m_prev = refresh;
        if (reset) begin
            q.delete();
            push_init();
            cur = q.pop_front();
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (cur.idle && rise) begin
                push_frame(int'(minutes), int'(seconds), int'(hundredths), lap_flag);
                cur = q.pop_front();
            end else begin
                cur = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
            end
        end
    end

    // Per-cycle comparison against the reference.
    always @(negedge clk_in) begin
        if (model_valid) begin
            checks++;
            if (lcd.e !== cur.e || busy !== cur.busy || frame_done !== cur.done || lcd.rw !== 1'b0 ||
                (!cur.idle && (lcd.rs !== cur.rs || lcd.db !== cur.db))) begin
                errors++;
                $display("FAIL cycle t=%0t act rs=%b db=%h e=%b rw=%b busy=%b done=%b exp rs=%b db=%h e=%b busy=%b done=%b",
                         $time, lcd.rs, lcd.db, lcd.e, lcd.rw, busy, frame_done,
                         cur.rs, cur.db, cur.e, cur.busy, cur.done);
            end
        end
    end

    // ---------------- monitor: completed writes and frame count ----------------
    logic [8:0] wr_q[$];
    logic       mon_e = 1'b0;
    int         frames_seen = 0;

    always @(negedge clk_in) begin
        if (mon_e && !lcd.e) wr_q.push_back({lcd.rs, lcd.db});
        mon_e = lcd.e;
        if (frame_done) frames_seen++;
    end

    // ---------------- literal expectations ----------------
    logic [8:0] init_exp [10] = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
    logic [8:0] f1_exp   [10] = '{9'h080, 9'h130, 9'h135, 9'h13A, 9'h134, 9'h132, 9'h12E, 9'h130, 9'h137, 9'h120};
    logic [8:0] f2_exp   [10] = '{9'h080, 9'h130, 9'h135, 9'h13A, 9'h131, 9'h133, 9'h12E, 9'h130, 9'h137, 9'h14C};
    logic [8:0] f3_exp   [10] = '{9'h080, 9'h139, 9'h139, 9'h13A, 9'h135, 9'h139, 9'h12E, 9'h139, 9'h139, 9'h120};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic check_writes(input string name, input int n, input logic [8:0] expv [10]);
        chk({name, "_count"}, 32'(wr_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wr_q.size()) chk($sformatf("%s_%0d", name, i), 32'(wr_q[i]), 32'(expv[i]));
        end
    endtask

    // Count cycles with busy high until it falls; a missing fall is a failure.
    task automatic busy_run(input string name, output int n);
        logic ended;
        n = 0;
        ended = 1'b0;
        for (int i = 0; i < MAXW && !ended; i++) begin
            @(negedge clk_in);
            if (busy) n++;
            else if (n > 0) ended = 1'b1;
        end
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy never fell within %0d cycles", name, MAXW);
        end
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk_in);
        refresh = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        logic pe;

        // Reset and power-on wait with a refresh request that must be ignored.
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        chk("rst_e", 32'(lcd.e), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_db", 32'(lcd.db), 32'h00);
        chk("rst_rs", 32'(lcd.rs), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        repeat (5) @(negedge clk_in);
        pulse_refresh();
        // 20 wait + 3*6 + 13 = 51 busy cycles, 7 already elapsed.
        busy_run("init", n);
        chk("init_busy_len", 32'(n), 32'd44);
        check_writes("init", 4, init_exp);
        chk("init_frames", 32'(frames_seen), 32'd0);

        // Frame 1; inputs change right after the request and must not show.
        repeat (3) @(negedge clk_in);
        minutes = 8'd5; seconds = 8'd42; hundredths = 8'd7; lap_flag = 1'b0;
        wr_q.delete();
        refresh = 1'b1;
        @(negedge clk_in);
        refresh = 1'b0; seconds = 8'd13; lap_flag = 1'b1;
        busy_run("f1", n);
        chk("f1_busy_len", 32'(n + 1), 32'd60);
        check_writes("f1", 10, f1_exp);
        chk("f1_frames", 32'(frames_seen), 32'd1);

        // Frame 2 shows the new seconds and lap marker.
        repeat (3) @(negedge clk_in);
        wr_q.delete();
        pulse_refresh();
        busy_run("f2", n);
        chk("f2_busy_len", 32'(n + 1), 32'd60);
        check_writes("f2", 10, f2_exp);
        chk("f2_frames", 32'(frames_seen), 32'd2);

        // Requests during a frame are dropped.
        repeat (3) @(negedge clk_in);
        wr_q.delete();
        pulse_refresh();
        repeat (10) @(negedge clk_in);
        pulse_refresh();
        repeat (10) @(negedge clk_in);
        pulse_refresh();
        busy_run("mid", n);
        chk("mid_busy_len", 32'(n), 32'd37);
        check_writes("mid", 10, f2_exp);
        repeat (5) @(negedge clk_in);
        chk("mid_idle_busy", 32'(busy), 32'd0);
        chk("mid_frames", 32'(frames_seen), 32'd3);

        // Request landing in the frame's final cycle is dropped.
        wr_q.delete();
        pulse_refresh();
        repeat (59) @(negedge clk_in);
        chk("last_cycle_done", 32'(frame_done), 32'd1);
        pulse_refresh();
        repeat (5) @(negedge clk_in);
        chk("last_idle_busy", 32'(busy), 32'd0);
        chk("last_frames", 32'(frames_seen), 32'd4);
        chk("last_writes", 32'(wr_q.size()), 32'd10);

        // Out-of-range values display as 99.
        minutes = 8'd150; seconds = 8'd59; hundredths = 8'd255; lap_flag = 1'b0;
        wr_q.delete();
        pulse_refresh();
        busy_run("clamp", n);
        check_writes("clamp", 10, f3_exp);
        chk("clamp_frames", 32'(frames_seen), 32'd5);

        // Reset during the strobe of the 4th data byte, then full init replay.
        repeat (3) @(negedge clk_in);
        minutes = 8'd5; seconds = 8'd13; hundredths = 8'd7; lap_flag = 1'b1;
        pulse_refresh();
        rises = 0;
        pe = lcd.e;
        for (int i = 0; i < MAXW && rises < 5; i++) begin
            @(negedge clk_in);
            if (lcd.e && !pe) rises++;
            pe = lcd.e;
        end
        chk("rst_mid_rises", 32'(rises), 32'd5);
        chk("rst_mid_e", 32'(lcd.e), 32'd1);
        chk("rst_mid_db", 32'({lcd.rs, lcd.db}), 32'h131);
        reset = 1'b1;
        @(negedge clk_in);
        chk("rst_mid_e_drop", 32'(lcd.e), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk_in);
        wr_q.delete();
        repeat (4) @(negedge clk_in);
        pulse_refresh();
        busy_run("replay", n);
        chk("replay_busy_len", 32'(n), 32'd44);
        check_writes("replay", 4, init_exp);
        chk("replay_frames", 32'(frames_seen), 32'd5);

        repeat (5) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
